// File: rtl/spi_peri_pkg.sv
// spi_peri_pkg: shared byte width, SPI mode and types for the SPI peripheral
package spi_peri_pkg;
  localparam int BYTE_W = 8;
  localparam int CNT_W = $clog2(BYTE_W);
  localparam logic [1:0] SPI_MODE = 2'b00;
  typedef logic [BYTE_W-1:0] byte_t;
  typedef logic [CNT_W-1:0] cnt_t;
endpackage

// File: rtl/spi_peri_sync_ff.sv
// sync_ff: 1-bit multi-stage synchronizer with synchronous reset value
module sync_ff #(
  parameter int DEPTH = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [DEPTH-1:0] sync_q, sync_d;
  // shift the asynchronous input one stage per clock
  always_comb sync_d = {sync_q[DEPTH-2:0], d};
  // stage register, forced to the idle level during reset
  always_ff @(posedge clk) sync_q <= rst ? {DEPTH{RST_VAL}} : sync_d;
  assign q = sync_q[DEPTH-1];
endmodule

// File: rtl/spi_peri.sv
// spi_peri: SPI mode-0 peripheral, MSB first, byte stream on rx_*/tx_*
module spi_peri
  import spi_peri_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spi_sck,
  input  logic        spi_csn,
  input  logic        spi_sdi,
  output logic        spi_sdo,
  output logic [7:0]  rx_data,
  output logic        rx_stb,
  input  logic [7:0]  tx_data,
  input  logic        tx_stb
);
  logic sck_s, csn_s, sdi_s;
  logic sck_prev_q, sck_prev_d, csn_prev_q, csn_prev_d;
  logic sck_rise, sck_fall, csn_fall, load;
  cnt_t cnt_q, cnt_d;
  byte_t rx_sr_q, rx_sr_d, rx_data_q, rx_data_d, so_q, so_d, tx_buf_q, tx_buf_d;
  logic rx_stb_q, rx_stb_d;

  sync_ff #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (.clk(clk), .rst(rst), .d(spi_sck), .q(sck_s));
  sync_ff #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_csn (.clk(clk), .rst(rst), .d(spi_csn), .q(csn_s));
  sync_ff #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sdi (.clk(clk), .rst(rst), .d(spi_sdi), .q(sdi_s));

  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;
  assign csn_fall = ~csn_s & csn_prev_q;
  // a byte slot starts at select and at the first falling edge after a completed byte
  assign load = csn_fall | (sck_fall & ~csn_s & (cnt_q == '0));

  // receive path: sample on rising edges, publish the byte when the counter wraps
  always_comb begin
    sck_prev_d = sck_s;
    csn_prev_d = csn_s;
    cnt_d = cnt_q;
    rx_sr_d = rx_sr_q;
    rx_data_d = rx_data_q;
    rx_stb_d = 1'b0;
    if (csn_s) cnt_d = '0;
    else if (sck_rise) begin
      rx_sr_d = {rx_sr_q[BYTE_W-2:0], sdi_s};
      cnt_d = cnt_q + 1'b1;
      rx_stb_d = (cnt_q == '1);
      rx_data_d = rx_stb_d ? rx_sr_d : rx_data_q;
    end
  end

  // transmit path: a strobe in a load cycle lands in the buffer after the load
  always_comb begin
    so_d = load ? tx_buf_q : (sck_fall & ~csn_s) ? {so_q[BYTE_W-2:0], 1'b0} : so_q;
    tx_buf_d = tx_stb ? tx_data : load ? '0 : tx_buf_q;
  end

  // state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_prev_q <= 1'b0;
      csn_prev_q <= 1'b1;
      cnt_q <= '0;
      rx_sr_q <= '0;
      rx_data_q <= '0;
      rx_stb_q <= 1'b0;
      so_q <= '0;
      tx_buf_q <= '0;
    end else begin
      sck_prev_q <= sck_prev_d;
      csn_prev_q <= csn_prev_d;
      cnt_q <= cnt_d;
      rx_sr_q <= rx_sr_d;
      rx_data_q <= rx_data_d;
      rx_stb_q <= rx_stb_d;
      so_q <= so_d;
      tx_buf_q <= tx_buf_d;
    end
  end

  assign spi_sdo = ~csn_s & so_q[BYTE_W-1];
  assign rx_data = rx_data_q;
  assign rx_stb = rx_stb_q;
endmodule
